// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - packet-level round-robin AXI-Stream arbiter with mid-packet timeout
module axis_rr_arbiter #(
  parameter int DATA_BITS      = 32,
  parameter int NUM_PORTS      = 4,
  parameter int TIMEOUT_CLOCKS = 1024
) (
  input  logic                             aclk,
  input  logic                             areset,
  input  logic [NUM_PORTS*DATA_BITS-1:0]   s_tdata,
  input  logic [NUM_PORTS*DATA_BITS/8-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]             s_tvalid,
  input  logic [NUM_PORTS-1:0]             s_tlast,
  output logic [NUM_PORTS-1:0]             s_tready,
  output logic [DATA_BITS-1:0]             m_tdata,
  output logic [DATA_BITS/8-1:0]           m_tkeep,
  output logic                             m_tvalid,
  output logic                             m_tlast,
  input  logic                             m_tready,
  output logic [NUM_PORTS-1:0]             grant,
  output logic                             timeout_pulse
);

  localparam int KEEP_BITS = DATA_BITS / 8;
  localparam int IDX_BITS  = $clog2(NUM_PORTS);
  localparam int TMR_BITS  = (TIMEOUT_CLOCKS > 1) ? $clog2(TIMEOUT_CLOCKS) : 1;

  // Timer value on the last idle cycle a stalled owner is allowed before the packet is closed.
  localparam logic [TMR_BITS-1:0] TMR_LIMIT =
    TMR_BITS'((TIMEOUT_CLOCKS > 0) ? TIMEOUT_CLOCKS - 1 : 0);
  localparam logic [IDX_BITS:0]   PORTS_W   = (IDX_BITS + 1)'(NUM_PORTS);
  localparam logic [IDX_BITS-1:0] LAST_PORT = IDX_BITS'(NUM_PORTS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_TERM
  } state_t;

  state_t                  state, state_d;
  logic [IDX_BITS-1:0]     owner, owner_d;
  logic [IDX_BITS-1:0]     last_port, last_d;
  logic [NUM_PORTS-1:0]    grant_d;
  logic [NUM_PORTS-1:0]    drop, drop_d;
  logic [TMR_BITS-1:0]     timer, timer_d;
  logic [DATA_BITS-1:0]    m_tdata_d;
  logic [KEEP_BITS-1:0]    m_tkeep_d;
  logic                    m_tvalid_d;
  logic                    m_tlast_d;
  logic                    pulse_d;

  logic                    ofree;
  logic [NUM_PORTS-1:0]    eligible;
  logic                    pick_valid;
  logic [IDX_BITS-1:0]     pick_idx;
  logic [IDX_BITS:0]       cand;

  // The output register can take a new beat when it is empty or being drained this cycle.
  assign ofree    = !m_tvalid || m_tready;

  // Ports still flushing a timed-out packet must not win arbitration.
  assign eligible = s_tvalid & ~drop;

  // Round-robin search starting just after the previous owner, wrapping at NUM_PORTS.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = {1'b0, last_port} + (IDX_BITS + 1)'(k);
      if (cand >= PORTS_W) begin
        cand = cand - PORTS_W;
      end
      if (!pick_valid && eligible[cand[IDX_BITS-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[IDX_BITS-1:0];
      end
    end
  end

  // Next-state, output-register loads, handshakes and drop-mask bookkeeping.
  always_comb begin
    state_d    = state;
    owner_d    = owner;
    last_d     = last_port;
    grant_d    = grant;
    drop_d     = drop;
    timer_d    = timer;
    m_tdata_d  = m_tdata;
    m_tkeep_d  = m_tkeep;
    m_tlast_d  = m_tlast;
    m_tvalid_d = m_tvalid && !m_tready;
    pulse_d    = 1'b0;
    s_tready   = drop;

    // A flushing port leaves drop once its tlast beat has been swallowed.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (drop[i] && s_tvalid[i] && s_tlast[i]) begin
        drop_d[i] = 1'b0;
      end
    end

    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_PASS;
          owner_d = pick_idx;
          last_d  = pick_idx;
          grant_d = NUM_PORTS'(1) << pick_idx;
          timer_d = '0;
        end
      end

      ST_PASS: begin
        s_tready[owner] = ofree;
        if (s_tvalid[owner]) begin
          // A waiting beat holds the timer even when the output is stalled.
          if (ofree) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = s_tdata[owner*DATA_BITS +: DATA_BITS];
            m_tkeep_d  = s_tkeep[owner*KEEP_BITS +: KEEP_BITS];
            m_tlast_d  = s_tlast[owner];
            timer_d    = '0;
            if (s_tlast[owner]) begin
              state_d = ST_IDLE;
              grant_d = '0;
            end
          end
        end else if (TIMEOUT_CLOCKS != 0) begin
          if (timer == TMR_LIMIT) begin
            state_d       = ST_TERM;
            grant_d       = '0;
            drop_d[owner] = 1'b1;
          end else begin
            timer_d = timer + TMR_BITS'(1);
          end
        end
      end

      ST_TERM: begin
        // Close the downstream packet with an empty tlast beat.
        if (ofree) begin
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b1;
          m_tkeep_d  = '0;
          m_tdata_d  = '0;
          pulse_d    = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any packet in flight without a closing beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= ST_IDLE;
      owner         <= '0;
      last_port     <= LAST_PORT;
      grant         <= '0;
      drop          <= '0;
      timer         <= '0;
      m_tdata       <= '0;
      m_tkeep       <= '0;
      m_tvalid      <= 1'b0;
      m_tlast       <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_d;
      owner         <= owner_d;
      last_port     <= last_d;
      grant         <= grant_d;
      drop          <= drop_d;
      timer         <= timer_d;
      m_tdata       <= m_tdata_d;
      m_tkeep       <= m_tkeep_d;
      m_tvalid      <= m_tvalid_d;
      m_tlast       <= m_tlast_d;
      timeout_pulse <= pulse_d;
    end
  end

endmodule
